// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: pipeline sequencing controller for the IF/ID and ID/EX
// pipeline registers.
//   - load-use hazard: one ID/EX bubble, PC and IF/ID frozen for one cycle
//   - taken branch: flush IF/ID and ID/EX, redirect PC to branch_target
//   - dmem_busy: whole front end frozen; a branch seen during the freeze is
//     held pending and redirected in the cycle after the freeze ends
//   - timeout_err: sticky, set once MAX_WAIT consecutive busy cycles are seen
// Ports:
//   clk, reset (async, active-high)
//   if_id_rs1/rs2/valid, id_ex_rd/memread/valid : hazard detection inputs
//   branch_taken, branch_target                 : branch resolution from EX
//   dmem_busy                                   : data memory not ready
//   pc_write, if_id_write, id_ex_write          : register update enables
//   id_ex_bubble, if_id_flush                   : bubble / NOP insertion
//   pc_sel, pc_target                           : PC redirect
//   timeout_err                                 : sticky busy-timeout flag
//   stall_cycles, flush_count                   : performance counters
// Build option: define HAZARD_PERF_CNT_EN to enable the performance counters;
// otherwise both counter outputs are tied to zero.
module hazard_ctrl_unit #(
  parameter int unsigned PC_W     = 64,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      if_id_rs1,
  input  logic [4:0]      if_id_rs2,
  input  logic            if_id_valid,
  input  logic [4:0]      id_ex_rd,
  input  logic            id_ex_memread,
  input  logic            id_ex_valid,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            dmem_busy,
  output logic            pc_write,
  output logic            if_id_write,
  output logic            id_ex_write,
  output logic            id_ex_bubble,
  output logic            if_id_flush,
  output logic            pc_sel,
  output logic [PC_W-1:0] pc_target,
  output logic            timeout_err,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     flush_count
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT, REDIRECT} state_e;

  state_e            state_q, state_d;
  logic              pend_q, pend_d;
  logic [PC_W-1:0]   pend_tgt_q, pend_tgt_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  logic              lu;

  logic              pc_write_c, if_id_write_c, id_ex_write_c;
  logic              bubble_c, flush_c, pc_sel_c;
  logic [PC_W-1:0]   pc_target_c;

  assign lu = id_ex_valid & id_ex_memread & if_id_valid & (id_ex_rd != 5'd0) &
              ((id_ex_rd == if_id_rs1) | (id_ex_rd == if_id_rs2));

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    pend_tgt_d    = pend_tgt_q;
    wait_cnt_d    = '0;
    pc_write_c    = 1'b1;
    if_id_write_c = 1'b1;
    id_ex_write_c = 1'b1;
    bubble_c      = 1'b0;
    flush_c       = 1'b0;
    pc_sel_c      = 1'b0;
    pc_target_c   = '0;

    case (state_q)
      RUN, LU_STALL: begin
        if (dmem_busy) begin
          pc_write_c    = 1'b0;
          if_id_write_c = 1'b0;
          id_ex_write_c = 1'b0;
          if (branch_taken) begin
            pend_d     = 1'b1;
            pend_tgt_d = branch_target;
          end
          wait_cnt_d = 8'd1;
          state_d    = MEM_WAIT;
        end else if (branch_taken) begin
          pc_sel_c    = 1'b1;
          pc_target_c = branch_target;
          flush_c     = 1'b1;
          bubble_c    = 1'b1;
          state_d     = RUN;
        end else if (lu && (state_q == RUN)) begin
          pc_write_c    = 1'b0;
          if_id_write_c = 1'b0;
          bubble_c      = 1'b1;
          state_d       = LU_STALL;
        end else begin
          state_d = RUN;
        end
      end

      MEM_WAIT: begin
        pc_write_c    = 1'b0;
        if_id_write_c = 1'b0;
        id_ex_write_c = 1'b0;
        if (branch_taken) begin
          pend_d     = 1'b1;
          pend_tgt_d = branch_target;
        end
        if (dmem_busy) begin
          wait_cnt_d = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
        end else begin
          state_d = (pend_q | branch_taken) ? REDIRECT : RUN;
        end
      end

      REDIRECT: begin
        // A freeze arriving here wins: the redirect stays pending and is
        // replayed once the freeze ends. A live branch here is wrong-path.
        if (dmem_busy) begin
          pc_write_c    = 1'b0;
          if_id_write_c = 1'b0;
          id_ex_write_c = 1'b0;
          wait_cnt_d    = 8'd1;
          state_d       = MEM_WAIT;
        end else begin
          pc_sel_c    = 1'b1;
          pc_target_c = pend_tgt_q;
          flush_c     = 1'b1;
          bubble_c    = 1'b1;
          pend_d      = 1'b0;
          state_d     = RUN;
        end
      end

      default: state_d = RUN;
    endcase

    timeout_d = timeout_q | (dmem_busy & (wait_cnt_d >= MAX_WAIT_C));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Control outputs are forced inactive for as long as reset is asserted.
  always_comb begin
    pc_write     = ~reset & pc_write_c;
    if_id_write  = ~reset & if_id_write_c;
    id_ex_write  = ~reset & id_ex_write_c;
    id_ex_bubble = ~reset & bubble_c;
    if_id_flush  = ~reset & flush_c;
    pc_sel       = ~reset & pc_sel_c;
    pc_target    = reset ? '0 : pc_target_c;
  end

  assign timeout_err = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write)   stall_cnt_d = stall_cnt_q + 32'd1;
    if (if_id_flush) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit (PC_W = 64, MAX_WAIT = 4).
// Directed vector table, hand-written multi-cycle sequences, then random
// stimulus compared against a cycle-level behavioural model.
module tb_hazard_ctrl_unit;

  localparam int unsigned MAXW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  if_id_rs1, if_id_rs2, id_ex_rd;
  logic        if_id_valid, id_ex_memread, id_ex_valid;
  logic        branch_taken, dmem_busy;
  logic [63:0] branch_target;
  logic        pc_write, if_id_write, id_ex_write, id_ex_bubble, if_id_flush, pc_sel;
  logic [63:0] pc_target;
  logic        timeout_err;
  logic [31:0] stall_cycles, flush_count;

  int n_cmp = 0;
  int n_err = 0;

  hazard_ctrl_unit #(.PC_W(64), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_valid(if_id_valid),
    .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread), .id_ex_valid(id_ex_valid),
    .branch_taken(branch_taken), .branch_target(branch_target), .dmem_busy(dmem_busy),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush), .pc_sel(pc_sel),
    .pc_target(pc_target), .timeout_err(timeout_err),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        ifv;
    logic [4:0]  rd;
    logic        mr, exv, br;
    logic [63:0] bt;
    logic        busy;
    logic        pw, ifw, idw, bub, fl, sel;
    logic [63:0] et;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic pw, input logic ifw, input logic idw,
                         input logic bub, input logic fl, input logic sel, input logic [63:0] et);
    chk({tag, ".pc_write"},     64'(pc_write),     64'(pw));
    chk({tag, ".if_id_write"},  64'(if_id_write),  64'(ifw));
    chk({tag, ".id_ex_write"},  64'(id_ex_write),  64'(idw));
    chk({tag, ".id_ex_bubble"}, 64'(id_ex_bubble), 64'(bub));
    chk({tag, ".if_id_flush"},  64'(if_id_flush),  64'(fl));
    chk({tag, ".pc_sel"},       64'(pc_sel),       64'(sel));
    chk({tag, ".pc_target"},    pc_target,         et);
  endtask

  function automatic logic [31:0] pexp(input longint v);
`ifdef HAZARD_PERF_CNT_EN
    return v[31:0];
`else
    return 32'd0;
`endif
  endfunction

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic ifv,
                        input logic [4:0] rd, input logic mr, input logic exv,
                        input logic br, input logic [63:0] bt, input logic busy);
    if_id_rs1 = rs1; if_id_rs2 = rs2; if_id_valid = ifv;
    id_ex_rd = rd; id_ex_memread = mr; id_ex_valid = exv;
    branch_taken = br; branch_target = bt; dmem_busy = busy;
    #1;
  endtask

  task automatic simple_in(input logic busy, input logic br, input logic [63:0] bt);
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, br, bt, busy);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset is released 1 time unit after a rising edge; the next step starts there.
  task automatic do_reset();
    simple_in(1'b0, 1'b0, 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- behavioural reference model ----------------
  bit          m_wait, m_prev_stall, m_redir, m_pend, m_to;
  logic [63:0] m_tgt;
  int          m_cnt;
  longint      m_stalls, m_flushes;
  logic        e_pw, e_ifw, e_idw, e_bub, e_fl, e_sel;
  logic [63:0] e_tgt;

  task automatic model_reset();
    m_wait = 0; m_prev_stall = 0; m_redir = 0; m_pend = 0; m_to = 0;
    m_tgt = '0; m_cnt = 0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic model_step();
    bit hazard, stall_now;
    hazard = id_ex_valid && id_ex_memread && if_id_valid && (id_ex_rd != 0) &&
             (id_ex_rd == if_id_rs1 || id_ex_rd == if_id_rs2);
    e_pw = 1; e_ifw = 1; e_idw = 1; e_bub = 0; e_fl = 0; e_sel = 0; e_tgt = '0;
    stall_now = 0;
    if (m_wait) begin
      e_pw = 0; e_ifw = 0; e_idw = 0;
      if (branch_taken) begin m_pend = 1; m_tgt = branch_target; end
      if (dmem_busy) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      else begin m_cnt = 0; m_wait = 0; m_redir = m_pend; end
    end else if (dmem_busy) begin
      e_pw = 0; e_ifw = 0; e_idw = 0;
      if (branch_taken && !m_redir) begin m_pend = 1; m_tgt = branch_target; end
      m_wait = 1; m_cnt = 1; m_redir = 0;
    end else if (m_redir) begin
      e_sel = 1; e_tgt = m_tgt; e_fl = 1; e_bub = 1;
      m_pend = 0; m_redir = 0;
    end else if (branch_taken) begin
      e_sel = 1; e_tgt = branch_target; e_fl = 1; e_bub = 1;
    end else if (hazard && !m_prev_stall) begin
      e_pw = 0; e_ifw = 0; e_bub = 1; stall_now = 1;
    end
    m_prev_stall = stall_now;
    if (dmem_busy && m_cnt >= int'(MAXW)) m_to = 1;
    if (!e_pw) m_stalls++;
    if (e_fl) m_flushes++;
  endtask

  vec_t vt[14];

  initial begin
    // rs1 rs2 ifv rd mr exv br bt busy | pw ifw idw bub fl sel et
    vt[0]  = '{0, 5, 1, 5, 1, 1, 0, 64'h0,    0, 0, 0, 1, 1, 0, 0, 64'h0};
    vt[1]  = '{0, 5, 1, 5, 1, 1, 0, 64'h0,    0, 1, 1, 1, 0, 0, 0, 64'h0};
    vt[2]  = '{0, 5, 1, 5, 1, 1, 0, 64'h0,    0, 0, 0, 1, 1, 0, 0, 64'h0};
    vt[3]  = '{0, 0, 1, 0, 1, 1, 0, 64'h0,    0, 1, 1, 1, 0, 0, 0, 64'h0};
    vt[4]  = '{0, 0, 1, 0, 1, 1, 0, 64'h0,    0, 1, 1, 1, 0, 0, 0, 64'h0};
    vt[5]  = '{5, 0, 0, 5, 1, 1, 0, 64'h0,    0, 1, 1, 1, 0, 0, 0, 64'h0};
    vt[6]  = '{5, 0, 1, 5, 1, 0, 0, 64'h0,    0, 1, 1, 1, 0, 0, 0, 64'h0};
    vt[7]  = '{5, 0, 1, 5, 0, 1, 0, 64'h0,    0, 1, 1, 1, 0, 0, 0, 64'h0};
    vt[8]  = '{0, 0, 0, 0, 0, 0, 1, 64'h1000, 0, 1, 1, 1, 1, 1, 1, 64'h1000};
    vt[9]  = '{0, 5, 1, 5, 1, 1, 1, 64'h3000, 0, 1, 1, 1, 1, 1, 1, 64'h3000};
    vt[10] = '{0, 5, 1, 5, 1, 1, 0, 64'h0,    0, 0, 0, 1, 1, 0, 0, 64'h0};
    vt[11] = '{0, 5, 1, 5, 1, 1, 0, 64'h0,    1, 0, 0, 0, 0, 0, 0, 64'h0};
    vt[12] = '{0, 0, 0, 0, 0, 0, 0, 64'h0,    0, 0, 0, 0, 0, 0, 0, 64'h0};
    vt[13] = '{0, 0, 0, 0, 0, 0, 0, 64'h0,    0, 1, 1, 1, 0, 0, 0, 64'h0};

    // Reset values while reset is held.
    reset = 1'b1;
    simple_in(1'b1, 1'b1, 64'hFFFF);
    chk_out("reset", 0, 0, 0, 0, 0, 0, 64'h0);
    chk("reset.timeout_err", 64'(timeout_err), 64'd0);
    chk("reset.stall_cycles", 64'(stall_cycles), 64'd0);
    chk("reset.flush_count", 64'(flush_count), 64'd0);
    tick();
    do_reset();

    // Directed vector table, applied back to back.
    for (int i = 0; i < 14; i++) begin
      set_in(vt[i].rs1, vt[i].rs2, vt[i].ifv, vt[i].rd, vt[i].mr, vt[i].exv,
             vt[i].br, vt[i].bt, vt[i].busy);
      chk_out($sformatf("vec%0d", i), vt[i].pw, vt[i].ifw, vt[i].idw, vt[i].bub,
              vt[i].fl, vt[i].sel, vt[i].et);
      tick();
    end
    chk("vec.stall_cycles", 64'(stall_cycles), 64'(pexp(5)));
    chk("vec.flush_count", 64'(flush_count), 64'(pexp(2)));
    chk("vec.timeout_err", 64'(timeout_err), 64'd0);

    // Branch during a 3-cycle freeze: redirect after the freeze ends.
    do_reset();
    simple_in(1'b1, 1'b0, 64'h0);      chk_out("frz.c1", 0, 0, 0, 0, 0, 0, 64'h0); tick();
    simple_in(1'b1, 1'b1, 64'h2000);   chk_out("frz.c2", 0, 0, 0, 0, 0, 0, 64'h0); tick();
    simple_in(1'b1, 1'b0, 64'h0);      chk_out("frz.c3", 0, 0, 0, 0, 0, 0, 64'h0); tick();
    simple_in(1'b0, 1'b0, 64'h0);
    chk("frz.stall_cycles", 64'(stall_cycles), 64'(pexp(3)));
    chk_out("frz.c4", 0, 0, 0, 0, 0, 0, 64'h0); tick();
    simple_in(1'b0, 1'b0, 64'h0);      chk_out("frz.redir", 1, 1, 1, 1, 1, 1, 64'h2000); tick();
    simple_in(1'b0, 1'b0, 64'h0);      chk_out("frz.after", 1, 1, 1, 0, 0, 0, 64'h0);
    chk("frz.flush_count", 64'(flush_count), 64'(pexp(1)));
    tick();

    // Timeout with MAX_WAIT = 4 and 6 busy cycles.
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      simple_in(1'b1, 1'b0, 64'h0);
      chk($sformatf("to.busy%0d", i), 64'(timeout_err), 64'(i >= 5));
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      simple_in(1'b0, 1'b0, 64'h0);
      chk($sformatf("to.idle%0d", i), 64'(timeout_err), 64'd1);
      tick();
    end
    do_reset();
    chk("to.cleared", 64'(timeout_err), 64'd0);

    // Async reset in MEM_WAIT with a pending branch.
    simple_in(1'b1, 1'b0, 64'h0);    tick();
    simple_in(1'b1, 1'b1, 64'h4000); tick();
    simple_in(1'b1, 1'b0, 64'h0);
    #2;
    reset = 1'b1;
    #1;
    chk_out("arst", 0, 0, 0, 0, 0, 0, 64'h0);
    chk("arst.stall_cycles", 64'(stall_cycles), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    simple_in(1'b0, 1'b0, 64'h0); chk_out("arst.rel0", 1, 1, 1, 0, 0, 0, 64'h0); tick();
    simple_in(1'b0, 1'b0, 64'h0); chk_out("arst.rel1", 1, 1, 1, 0, 0, 0, 64'h0); tick();

    // Random stimulus against the model.
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 5) == 0), {$urandom, $urandom},
             1'($urandom_range(0, 3) == 0));
      chk($sformatf("rnd%0d.timeout_err", c), 64'(timeout_err), 64'(m_to));
      chk($sformatf("rnd%0d.stall_cycles", c), 64'(stall_cycles), 64'(pexp(m_stalls)));
      chk($sformatf("rnd%0d.flush_count", c), 64'(flush_count), 64'(pexp(m_flushes)));
      model_step();
      chk_out($sformatf("rnd%0d", c), e_pw, e_ifw, e_idw, e_bub, e_fl, e_sel, e_tgt);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
